// File: rtl/switch_debouncer.sv
// Switch input conditioning: two-flop synchroniser, shared tick prescaler and
// per-bit stability counters producing clean levels, edge pulses and a sticky change flag.
module switch_debouncer #(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             clear_change,
  output logic [WIDTH-1:0] sw_debounced,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             change_pending
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    P_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] accept;

  assign tick = (pcnt == P_LAST);

  // Any cycle where the synchronised level matches the accepted one restarts the filter.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (s2[i] == sw_debounced[i]) begin
        cnt_next[i] = '0;
      end else if (tick) begin
        if (cnt[i] == C_LAST) begin
          accept[i]   = 1'b1;
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1             <= '0;
      s2             <= '0;
      pcnt           <= '0;
      sw_debounced   <= '0;
      sw_rise        <= '0;
      sw_fall        <= '0;
      change_pending <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      s1   <= sw_raw;
      s2   <= s1;
      pcnt <= tick ? '0 : pcnt + PW'(1);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      sw_debounced <= (sw_debounced & ~accept) | (s2 & accept);
      sw_rise      <= accept & s2;
      sw_fall      <= accept & ~s2;
      // A new acceptance outranks a simultaneous clear so no change is lost.
      if (|accept)           change_pending <= 1'b1;
      else if (clear_change) change_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: per-cycle reference model feeding a scoreboard queue,
// a table of level/clear vectors, and directed latency, glitch and reset sequences.
module tb_switch_debouncer;
  localparam int W  = 16;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear_change;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_debounced;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         change_pending;

  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .clear_change(clear_change),
    .sw_debounced(sw_debounced), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .change_pending(change_pending)
  );

  typedef struct packed {
    logic [W-1:0] deb;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         cp;
  } exp_t;

  typedef struct {
    logic [W-1:0] raw;
    logic         clr;
    int           hold;
    logic [W-1:0] exp_deb;
    logic         exp_cp;
  } vec_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model state (reflects the DUT registers after the latest edge)
  logic [W-1:0] m_s1, m_s2, m_deb, m_rise, m_fall;
  logic         m_cp;
  int           m_pcnt;
  int           m_cnt [W];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] n_deb, n_rise, n_fall;
    bit tk;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_rise = '0; m_fall = '0; m_cp = 1'b0;
      m_pcnt = 0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
    end else begin
      tk = (m_pcnt == TD - 1);
      n_deb = m_deb; n_rise = '0; n_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_deb[i]) m_cnt[i] = 0;
        else if (tk) begin
          if (m_cnt[i] == ST - 1) begin
            n_deb[i] = m_s2[i];
            if (m_s2[i]) n_rise[i] = 1'b1; else n_fall[i] = 1'b1;
            m_cnt[i] = 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if ((n_rise | n_fall) != '0) m_cp = 1'b1;
      else if (clear_change)       m_cp = 1'b0;
      m_pcnt = tk ? 0 : m_pcnt + 1;
      m_s2 = m_s1; m_s1 = sw_raw;
      m_deb = n_deb; m_rise = n_rise; m_fall = n_fall;
    end
  endtask

  // One clock: predict, push, clock, pop and compare against the DUT.
  task automatic step();
    exp_t e, got;
    model_edge();
    e.deb = m_deb; e.rise = m_rise; e.fall = m_fall; e.cp = m_cp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = '{sw_debounced, sw_rise, sw_fall, change_pending};
    e = sb_q.pop_front();
    chk("cycle", 64'(got), 64'(e));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic lone_clear(input string name);
    clear_change = 1'b1;
    step();
    clear_change = 1'b0;
    chk(name, 64'(change_pending), 64'd0);
  endtask

  initial begin
    vec_t vt[$];
    int n;
    logic acc3;

    vt.push_back('{16'hFFFF, 1'b0, 20, 16'hFFFF, 1'b1});
    vt.push_back('{16'hFFFF, 1'b1, 20, 16'hFFFF, 1'b0});
    vt.push_back('{16'h00FF, 1'b0, 20, 16'h00FF, 1'b1});
    vt.push_back('{16'h00FF, 1'b1, 20, 16'h00FF, 1'b0});
    vt.push_back('{16'h1234, 1'b0, 20, 16'h1234, 1'b1});
    vt.push_back('{16'h1234, 1'b1,  3, 16'h1234, 1'b0});
    vt.push_back('{16'h8001, 1'b0,  5, 16'h1234, 1'b0});
    vt.push_back('{16'h8001, 1'b0, 20, 16'h8001, 1'b1});

    reset = 1'b1; clear_change = 1'b0; sw_raw = '0;
    #1;
    steps(2);
    reset = 1'b0;
    steps(48);
    chk("reset_state", 64'({sw_debounced, sw_rise, sw_fall, change_pending}), 64'd0);

    // clean step on bit 0
    sw_raw = 16'h0001;
    n = 0;
    do begin step(); n++; end while (!sw_debounced[0] && n < 30);
    chk("bit0_latency_11_14", 64'(n >= 11 && n <= 14), 64'd1);
    chk("bit0_rise", 64'(sw_rise), 64'h0001);
    chk("bit0_cp", 64'(change_pending), 64'd1);
    step();
    chk("bit0_rise_one_cycle", 64'(sw_rise), 64'd0);

    // short glitch on bit 3
    lone_clear("clear_before_glitch");
    sw_raw = 16'h0009;
    acc3 = 1'b0;
    for (int k = 0; k < 6; k++) begin step(); acc3 |= sw_rise[3] | sw_fall[3]; end
    sw_raw = 16'h0001;
    for (int k = 0; k < 30; k++) begin step(); acc3 |= sw_rise[3] | sw_fall[3]; end
    chk("glitch_deb", 64'(sw_debounced), 64'h0001);
    chk("glitch_no_pulse", 64'(acc3), 64'd0);
    chk("glitch_no_cp", 64'(change_pending), 64'd0);

    // multi-bit step
    sw_raw = 16'hA5A4;
    n = 0;
    do begin step(); n++; end while (sw_debounced == 16'h0001 && n < 30);
    chk("multi_deb", 64'(sw_debounced), 64'hA5A4);
    chk("multi_rise", 64'(sw_rise), 64'hA5A4);
    chk("multi_fall", 64'(sw_fall), 64'h0001);
    step();
    chk("multi_pulse_one_cycle", 64'({sw_rise, sw_fall}), 64'd0);

    // clear coinciding with a fall acceptance: set wins
    lone_clear("lone_clear_1");
    sw_raw = 16'hA5A0;
    clear_change = 1'b1;
    n = 0;
    do begin step(); n++; end while (sw_fall == '0 && n < 30);
    clear_change = 1'b0;
    chk("coincide_fall", 64'(sw_fall), 64'h0004);
    chk("coincide_cp_set", 64'(change_pending), 64'd1);
    step();
    chk("coincide_cp_held", 64'(change_pending), 64'd1);
    lone_clear("lone_clear_2");

    // reset mid-debounce on bit 5
    sw_raw = 16'h0000;
    steps(20);
    lone_clear("clear_before_reset");
    chk("settled_zero", 64'(sw_debounced), 64'd0);
    sw_raw = 16'h0020;
    n = 0;
    while (m_cnt[5] != 2 && n < 30) begin step(); n++; end
    chk("reached_cnt2", 64'(m_cnt[5] == 2), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_reset_outputs", 64'({sw_debounced, sw_rise, sw_fall, change_pending}), 64'd0);
    n = 0;
    do begin step(); n++; end while (!sw_debounced[5] && n < 30);
    chk("bit5_restart_latency", 64'(n), 64'd12);
    chk("bit5_rise", 64'(sw_rise), 64'h0020);

    // table-driven level / clear vectors
    foreach (vt[j]) begin
      sw_raw = vt[j].raw;
      clear_change = vt[j].clr;
      step();
      clear_change = 1'b0;
      steps(vt[j].hold - 1);
      chk($sformatf("vec%0d_deb", j), 64'(sw_debounced), 64'(vt[j].exp_deb));
      chk($sformatf("vec%0d_cp", j), 64'(change_pending), 64'(vt[j].exp_cp));
    end

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
